decode_stage: RTL
=================

# decode_stage

Registered, parametrised instruction-decode pipeline stage with a valid/ready handshake on both sides. It sits between instruction fetch and register read. It splits each instruction word into opcode, function code, two register indices, shift amount and an extended immediate. A two-entry skid buffer lets it sustain one instruction per cycle under downstream backpressure. It adds pipeline flush, per-opcode immediate extension mode, PC pass-through and a decoded-instruction counter.

## Interface
Parameters:
- XLEN, 32: width of immediate output and PC; must be ≥ 16.
- ZERO_EXT_MASK, 16'h0000: bit k = 1 means opcode k zero-extends its immediate; 0 means sign-extend.
- COUNT_W, 32: width of decoded_count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_opcode  out  4  instr[31:28].
- out_fncode  out  4  instr[3:0].
- out_reg1  out  5  instr[27:23].
- out_reg2  out  5  instr[22:18].
- out_shamt  out  6  instr[17:12].
- out_imm  out  XLEN  instr[22:7], extended to XLEN.
- out_pc  out  XLEN  PC carried with the instruction.
- decoded_count  out  COUNT_W  number of output transfers since reset.

## Operation
- Input transfer: in_valid && in_ready at a clock edge. Output transfer: out_valid && out_ready at a clock edge.
- Storage consists of a main register, which drives all out_* signals, and a skid register. Each holds the decoded fields plus PC and a valid bit.
- Decoding happens at capture time, so stored values are already decoded.
- Immediate extension:
  - imm16 = instr[22:7].
  - If ZERO_EXT_MASK[opcode] = 1: out_imm = {(XLEN-16) zeros, imm16}.
  - Otherwise: out_imm = {(XLEN-16) copies of imm16[15], imm16}.
- in_ready = !skid_valid. It is a register-derived value with no combinational path from out_ready.
- Per-edge update, when not in reset and not flushing:
  - Main empty, or output transfer this cycle:
    - If skid is valid, main loads from skid and skid clears.
    - If an input transfer also occurs in this case, it loads into skid.
    - Otherwise main loads from the input transfer if there is one, else main_valid clears.
  - Main full, no output transfer, and an input transfer occurs: the input loads into skid. This is only possible while skid is empty.
- Order is strictly FIFO; no instruction is dropped or duplicated.
- out_valid = main_valid.
- decoded_count increments by 1 on each output transfer and wraps from 2^COUNT_W−1 to 0.
- flush = 1 at an edge:
  - Both valid bits clear.
  - The input in that cycle is ignored, even if in_ready was high.
  - An output transfer in that cycle still counts.
  - Payload registers keep their values; only the valid bits matter.
- flush has priority over capture. reset_n has priority over flush.

## Timing
- Reset (reset_n = 0 at an edge): main_valid = skid_valid = 0, all payload outputs = 0, decoded_count = 0. Hence out_valid = 0 and in_ready = 1 from the first edge with reset_n low.
- Latency: an instruction accepted at edge N appears on out_* with out_valid = 1 after edge N, when the stage is empty.
- Throughput is 1 instruction per cycle while out_ready = 1.
- Backpressure: with out_ready = 0 the stage accepts two instructions. in_ready falls after the edge that fills skid. in_ready rises again after the first output transfer following that edge.
- Simultaneous input transfer and output transfer with skid empty: main is replaced by the new instruction and out_valid stays 1.
- Reset mid-operation discards both entries immediately at the edge. No output transfer is counted on that edge.
- Outputs are stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, out_imm = 0, decoded_count = 0. No instruction is captured.
- Basic decode: in_instr = 0x21905007, in_pc = 0x100, out_ready = 1 → one cycle later: out_opcode = 2, out_reg1 = 3, out_reg2 = 4, out_shamt = 5, out_fncode = 7, out_imm = 0x000020A0, out_pc = 0x100, decoded_count = 1.
- Extension mode: in_instr = 0x30400000 (imm16 = 0x8000):
  - Default mask → out_imm = 0xFFFF8000.
  - ZERO_EXT_MASK = 16'h0008 → out_imm = 0x00008000.
- Backpressure: out_ready = 0, offer I0, I1, I2 on consecutive cycles → I0 and I1 accepted, in_ready = 0 during I2. Then out_ready = 1 → outputs in order I0, I1, I2 on consecutive cycles, decoded_count = 3, no gaps after the first.
- Flush: main and skid both full, in_valid = 1, pulse flush for one cycle → out_valid = 0 and in_ready = 1 next cycle, decoded_count unchanged. The instruction offered in the flush cycle is never output.
- Counter wrap: COUNT_W = 4, 17 back-to-back transfers → decoded_count = 1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with a two-entry skid
// buffer, flush, per-opcode immediate extension, PC pass-through and a
// count of decoded instructions handed downstream.
module decode_stage #(
   parameter int          XLEN          = 32,
   parameter logic [15:0] ZERO_EXT_MASK = 16'h0000,
   parameter int          COUNT_W       = 32
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_flush,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [31:0]        i_in_instr,
   input  logic [XLEN-1:0]    i_in_pc,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [3:0]         o_out_opcode,
   output logic [3:0]         o_out_fncode,
   output logic [4:0]         o_out_reg1,
   output logic [4:0]         o_out_reg2,
   output logic [5:0]         o_out_shamt,
   output logic [XLEN-1:0]    o_out_imm,
   output logic [XLEN-1:0]    o_out_pc,
   output logic [COUNT_W-1:0] o_decoded_count
);

   // decoded payload held in both the main and the skid register
   typedef struct packed {
      logic [3:0]      opcode;
      logic [3:0]      fncode;
      logic [4:0]      reg1;
      logic [4:0]      reg2;
      logic [5:0]      shamt;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } dec_t;

   dec_t               r_main;
   dec_t               r_skid;
   logic               r_main_valid;
   logic               r_skid_valid;
   logic [COUNT_W-1:0] r_count;

   dec_t               w_dec;
   logic [15:0]        w_imm16;
   logic               w_in_xfer;
   logic               w_out_xfer;

   // ready depends only on skid occupancy, so out_ready never reaches in_ready
   assign w_in_xfer  = i_in_valid && !r_skid_valid;
   assign w_out_xfer = r_main_valid && i_out_ready;
   assign w_imm16    = i_in_instr[22:7];

   // decode the incoming word so storage only ever holds decoded fields
   always_comb begin
      w_dec        = '0;
      w_dec.opcode = i_in_instr[31:28];
      w_dec.fncode = i_in_instr[3:0];
      w_dec.reg1   = i_in_instr[27:23];
      w_dec.reg2   = i_in_instr[22:18];
      w_dec.shamt  = i_in_instr[17:12];
      w_dec.imm    = ZERO_EXT_MASK[i_in_instr[31:28]] ? XLEN'(w_imm16)
                                                      : XLEN'($signed(w_imm16));
      w_dec.pc     = i_in_pc;
   end

   // main/skid occupancy, payload capture and transfer counter
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_count      <= '0;
      end else begin
         // a transfer seen in a flush cycle still happened downstream
         if (w_out_xfer)
            r_count <= r_count + COUNT_W'(1);
         if (i_flush) begin
            // payload left as-is; only the valid bits matter
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
         end else if (!r_main_valid || w_out_xfer) begin
            if (r_skid_valid) begin
               r_main       <= r_skid;
               r_main_valid <= 1'b1;
               r_skid_valid <= w_in_xfer;
               if (w_in_xfer)
                  r_skid <= w_dec;
            end else if (w_in_xfer) begin
               r_main       <= w_dec;
               r_main_valid <= 1'b1;
            end else begin
               r_main_valid <= 1'b0;
            end
         end else if (w_in_xfer) begin
            // main is stalled; park the new instruction in the skid slot
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
         end
      end
   end

   assign o_in_ready      = !r_skid_valid;
   assign o_out_valid     = r_main_valid;
   assign o_out_opcode    = r_main.opcode;
   assign o_out_fncode    = r_main.fncode;
   assign o_out_reg1      = r_main.reg1;
   assign o_out_reg2      = r_main.reg2;
   assign o_out_shamt     = r_main.shamt;
   assign o_out_imm       = r_main.imm;
   assign o_out_pc        = r_main.pc;
   assign o_decoded_count = r_count;

endmodule
